// File: rtl/mul_defs_pkg.sv
// Shared multiply definitions: opcode and FSM encodings, widths, operand helpers.
// The decoder imports this package as well.
package mul_defs;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ITER_N = 32;
   localparam int unsigned REG_W  = 4;
   localparam int unsigned IMM_W  = 16;
   localparam int unsigned CNT_W  = 6;

   typedef enum logic [1:0] {
      MUL_I  = 2'd0,
      MUL_R  = 2'd1,
      MUL_SI = 2'd2,
      MUL_SR = 2'd3
   } mul_type_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_ITER = 3'd2,
      ST_FIX  = 3'd3,
      ST_WB   = 3'd4
   } mul_state_e;

   // Request fields held for the life of one multiply
   typedef struct packed {
      mul_type_e        typ;
      logic [REG_W-1:0] dest;
      logic [IMM_W-1:0] imm;
   } mul_req_t;

   function automatic logic is_signed_type(mul_type_e t);
      return (t == MUL_SI) || (t == MUL_SR);
   endfunction

   function automatic logic [DATA_W-1:0] ext_imm(logic [IMM_W-1:0] v, logic sext);
      return sext ? {{(DATA_W-IMM_W){v[IMM_W-1]}}, v}
                  : {{(DATA_W-IMM_W){1'b0}}, v};
   endfunction

endpackage

// File: rtl/mul_shift_add_core.sv
// Radix-2 shift-add datapath on operand magnitudes; sign is reapplied by the fix strobe.
module mul_shift_add_core
   import mul_defs::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic              fix,
   input  logic              is_signed,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic [DATA_W-1:0] result_c
);

   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] mcand;
   logic [DATA_W-1:0] mplier;
   logic              sign;
   logic              a_neg_c;
   logic              b_neg_c;
   logic [DATA_W-1:0] mag_a_c;
   logic [DATA_W-1:0] mag_b_c;

   assign a_neg_c  = is_signed & op_a[DATA_W-1];
   assign b_neg_c  = is_signed & op_b[DATA_W-1];
   assign mag_a_c  = a_neg_c ? -op_a : op_a;
   assign mag_b_c  = b_neg_c ? -op_b : op_b;
   assign result_c = sign ? -acc : acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         sign   <= 1'b0;
      end else if (load) begin
         acc    <= '0;
         mcand  <= mag_a_c;
         mplier <= mag_b_c;
         sign   <= a_neg_c ^ b_neg_c;
      end else if (step) begin
         if (mplier[0]) acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end else if (fix) begin
         acc <= result_c;
      end
   end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle multiply sequencer: captures a decoded request, reads operands,
// runs the shift-add core for a fixed 32 iterations and writes the product back.
module mul_sequencer
   import mul_defs::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              mul_trigger,
   input  logic [1:0]        mul_type,
   input  logic [REG_W-1:0]  dest_reg,
   input  logic [REG_W-1:0]  src1_reg,
   input  logic [REG_W-1:0]  src2_reg,
   input  logic [IMM_W-1:0]  imm,
   output logic [REG_W-1:0]  rd_addr1,
   output logic [REG_W-1:0]  rd_addr2,
   input  logic [DATA_W-1:0] rs1_data,
   input  logic [DATA_W-1:0] rs2_data,
   output logic              stall,
   output logic              wb_en,
   output logic [REG_W-1:0]  wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic              flag_n,
   output logic              flag_z,
   output logic              busy
);

   mul_state_e        state;
   mul_state_e        next_state;
   mul_req_t          req;
   logic [CNT_W-1:0]  cnt;
   logic              accept_c;
   logic              load_c;
   logic              step_c;
   logic              fix_c;
   logic [DATA_W-1:0] op_b_c;
   logic [DATA_W-1:0] result_c;

   assign accept_c = mul_trigger && (state == ST_IDLE);
   // Stall must assert in the trigger cycle itself, before busy rises
   assign stall    = rst & (busy | accept_c);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      load_c     = 1'b0;
      step_c     = 1'b0;
      fix_c      = 1'b0;
      case (state)
         ST_IDLE: if (mul_trigger) next_state = ST_LOAD;
         ST_LOAD: begin
            load_c     = 1'b1;
            next_state = ST_ITER;
         end
         ST_ITER: begin
            step_c = 1'b1;
            if (cnt == CNT_W'(ITER_N - 1)) next_state = ST_FIX;
         end
         ST_FIX: begin
            fix_c      = 1'b1;
            next_state = ST_WB;
         end
         ST_WB:   next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      op_b_c = ext_imm(req.imm, 1'b0);
      case (req.typ)
         MUL_R, MUL_SR: op_b_c = rs2_data;
         MUL_SI:        op_b_c = ext_imm(req.imm, 1'b1);
         default:       op_b_c = ext_imm(req.imm, 1'b0);
      endcase
   end

   // Request capture; source indices live in rd_addr1/rd_addr2 during LOAD
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req <= '0;
      end else if (accept_c) begin
         req <= '{typ: mul_type_e'(mul_type), dest: dest_reg, imm: imm};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        cnt <= '0;
      else if (step_c) cnt <= cnt + CNT_W'(1);
      else             cnt <= '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy     <= 1'b0;
         rd_addr1 <= '0;
         rd_addr2 <= '0;
      end else begin
         busy     <= (next_state != ST_IDLE);
         rd_addr1 <= accept_c ? src1_reg : '0;
         rd_addr2 <= accept_c ? src2_reg : '0;
      end
   end

   // Write-back registers load from the sign-corrected result as FIX completes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_en   <= 1'b0;
         wb_addr <= '0;
         wb_data <= '0;
         flag_n  <= 1'b0;
         flag_z  <= 1'b0;
      end else if (fix_c) begin
         wb_en   <= 1'b1;
         wb_addr <= req.dest;
         wb_data <= result_c;
         flag_n  <= result_c[DATA_W-1];
         flag_z  <= (result_c == '0);
      end else begin
         wb_en   <= 1'b0;
         wb_addr <= '0;
         wb_data <= '0;
         flag_n  <= 1'b0;
         flag_z  <= 1'b0;
      end
   end

   mul_shift_add_core u_core (
      .clk       (clk),
      .rst_n     (rst),
      .load      (load_c),
      .step      (step_c),
      .fix       (fix_c),
      .is_signed (is_signed_type(req.typ)),
      .op_a      (rs1_data),
      .op_b      (op_b_c),
      .result_c  (result_c)
   );

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a small register-file model.
module tb_mul_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        mul_trigger;
   logic [1:0]  mul_type;
   logic [3:0]  dest_reg, src1_reg, src2_reg;
   logic [15:0] imm;
   logic [3:0]  rd_addr1, rd_addr2;
   logic [31:0] rs1_data, rs2_data;
   logic        stall, wb_en, flag_n, flag_z, busy;
   logic [3:0]  wb_addr;
   logic [31:0] wb_data;

   logic [31:0] rf [16];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign rs1_data = rf[rd_addr1];
   assign rs2_data = rf[rd_addr2];

   mul_sequencer dut (
      .clk(clk), .rst(rst), .mul_trigger(mul_trigger), .mul_type(mul_type),
      .dest_reg(dest_reg), .src1_reg(src1_reg), .src2_reg(src2_reg), .imm(imm),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .stall(stall), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .flag_n(flag_n), .flag_z(flag_z), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One complete multiply; cycle n counts from the trigger edge T (n=1 is LOAD)
   task automatic run_op(input string tag, input logic [1:0] typ, input logic [3:0] dst,
                         input logic [3:0] s1, input logic [3:0] s2, input logic [15:0] im,
                         input logic [31:0] exp_data, input logic exp_n, input logic exp_z);
      int wb_count = 0;
      int wb_cycle = -1;
      @(negedge clk);
      mul_type = typ; dest_reg = dst; src1_reg = s1; src2_reg = s2; imm = im;
      mul_trigger = 1'b1;
      #1;
      chk({tag, ".stall_trig"}, 32'(stall), 32'd1);
      @(negedge clk);
      mul_trigger = 1'b0;
      chk({tag, ".busy_load"}, 32'(busy), 32'd1);
      chk({tag, ".rd_addr1"}, 32'(rd_addr1), 32'(s1));
      chk({tag, ".rd_addr2"}, 32'(rd_addr2), 32'(s2));
      for (int n = 2; n <= 40; n++) begin
         @(negedge clk);
         if (wb_en) begin
            wb_count++;
            if (wb_cycle < 0) wb_cycle = n;
         end
         if (n == 34) chk({tag, ".wb_data_pre"}, wb_data, 32'd0);
         if (n == 35) begin
            chk({tag, ".wb_en"}, 32'(wb_en), 32'd1);
            chk({tag, ".wb_addr"}, 32'(wb_addr), 32'(dst));
            chk({tag, ".wb_data"}, wb_data, exp_data);
            chk({tag, ".flag_n"}, 32'(flag_n), 32'(exp_n));
            chk({tag, ".flag_z"}, 32'(flag_z), 32'(exp_z));
         end
         if (n == 36) begin
            chk({tag, ".busy_idle"}, 32'(busy), 32'd0);
            chk({tag, ".wb_data_post"}, wb_data, 32'd0);
         end
      end
      chk({tag, ".wb_count"}, 32'(wb_count), 32'd1);
      chk({tag, ".wb_cycle"}, 32'(wb_cycle), 32'd35);
   endtask

   initial begin
      int wb_count;
      int wb_second;
      foreach (rf[i]) rf[i] = 32'h0;
      rf[1] = 32'd7;
      rf[2] = 32'hFFFF_FFFD;
      rf[3] = 32'hFFFF_FFFC;
      rf[4] = 32'd6;
      rf[5] = 32'h0001_0000;
      rf[6] = 32'd2;
      rst = 1'b0; mul_trigger = 1'b0; mul_type = 2'd0;
      dest_reg = 4'd0; src1_reg = 4'd0; src2_reg = 4'd0; imm = 16'h0;
      #2;
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.stall", 32'(stall), 32'd0);
      chk("rst.wb_en", 32'(wb_en), 32'd0);
      chk("rst.wb_data", wb_data, 32'd0);
      chk("rst.rd_addr1", 32'(rd_addr1), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      run_op("muli",   2'd0, 4'd3,  4'd1, 4'd3, 16'h0006, 32'd42,         1'b0, 1'b0);
      run_op("mulsi",  2'd2, 4'd4,  4'd2, 4'd0, 16'hFFFB, 32'h0000_000F,  1'b0, 1'b0);
      run_op("mulsr",  2'd3, 4'd5,  4'd3, 4'd4, 16'h0000, 32'hFFFF_FFE8,  1'b1, 1'b0);
      run_op("mulr_w", 2'd1, 4'd6,  4'd5, 4'd5, 16'h0000, 32'h0000_0000,  1'b0, 1'b1);
      run_op("muli_z", 2'd0, 4'd7,  4'd6, 4'd0, 16'h8000, 32'h0001_0000,  1'b0, 1'b0);
      run_op("mulsi_s",2'd2, 4'd8,  4'd6, 4'd0, 16'h8000, 32'hFFFF_0000,  1'b1, 1'b0);
      run_op("mulr_u", 2'd1, 4'd11, 4'd2, 4'd2, 16'h0000, 32'h0000_0009,  1'b0, 1'b0);

      // Trigger held through the operation with changing fields, then back-to-back
      @(negedge clk);
      mul_type = 2'd0; dest_reg = 4'd9; src1_reg = 4'd1; src2_reg = 4'd0; imm = 16'd3;
      mul_trigger = 1'b1;
      wb_count = 0;
      wb_second = -1;
      for (int n = 1; n <= 75; n++) begin
         @(negedge clk);
         if (wb_en) begin
            wb_count++;
            if (n > 36 && wb_second < 0) wb_second = n;
         end
         if (n <= 33) begin
            mul_type = 2'd3; dest_reg = 4'(n); src1_reg = 4'd2; imm = 16'hFFFF;
         end
         if (n == 34) mul_trigger = 1'b0;
         if (n == 35) begin
            chk("hold.wb_addr", 32'(wb_addr), 32'd9);
            chk("hold.wb_data", wb_data, 32'd21);
         end
         if (n == 36) begin
            mul_type = 2'd1; dest_reg = 4'd10; src1_reg = 4'd1; src2_reg = 4'd4; imm = 16'h0;
            mul_trigger = 1'b1;
         end
         if (n == 37) mul_trigger = 1'b0;
         if (n == 71) begin
            chk("b2b.wb_addr", 32'(wb_addr), 32'd10);
            chk("b2b.wb_data", wb_data, 32'd42);
         end
      end
      chk("hold.wb_count", 32'(wb_count), 32'd2);
      chk("b2b.wb_cycle", 32'(wb_second), 32'd71);

      // Reset during ITER aborts with no write-back
      @(negedge clk);
      mul_type = 2'd1; dest_reg = 4'd12; src1_reg = 4'd1; src2_reg = 4'd4;
      mul_trigger = 1'b1;
      @(negedge clk);
      mul_trigger = 1'b0;
      for (int n = 2; n <= 12; n++) @(negedge clk);
      rst = 1'b0;
      mul_trigger = 1'b1;
      #1;
      chk("arst.busy", 32'(busy), 32'd0);
      chk("arst.stall", 32'(stall), 32'd0);
      chk("arst.rd_addr2", 32'(rd_addr2), 32'd0);
      chk("arst.wb_en", 32'(wb_en), 32'd0);
      @(negedge clk);
      @(negedge clk);
      mul_trigger = 1'b0;
      rst = 1'b1;
      wb_count = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (wb_en) wb_count++;
      end
      chk("arst.no_wb", 32'(wb_count), 32'd0);
      run_op("post_rst", 2'd3, 4'd13, 4'd3, 4'd3, 16'h0000, 32'h0000_0010, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
